// File: rtl/imem_loader.sv
// imem_loader: streams a program into the 256-word instruction store over a
// valid/ready handshake. It stalls and kills the pipeline while loading, drains
// for FLUSH_CYCLES cycles, then redirects the PC to the load base address.
// Optional feature: define LOADER_CHECKSUM_EN to add the expected_sum port, a
// running modulo-2**32 sum of accepted words, and a HALT state on mismatch.
module imem_loader #(
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
`ifdef LOADER_CHECKSUM_EN
    input  logic [31:0]       expected_sum,
`endif
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              cpu_kill,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
`ifdef LOADER_CHECKSUM_EN
        , ST_HALT = 2'd3
`endif
    } state_t;

    localparam logic [ADDR_W+1:0] LP_DEPTH      = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_REM_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_ADDR_ONE   = (ADDR_W)'(1);
    localparam logic [3:0]        LP_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    // State and counters
    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_flush_cnt;
    logic [3:0]          w_flush_cnt_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W-1:0]   r_base;

    // Decoded control
    logic                w_xfer;
    logic                w_last;
    logic [ADDR_W+1:0]   w_end;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_finish;
    logic                w_err_next;
    logic                w_redirect_next;

    // Registered outputs
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_cpu_stall;
    logic                r_cpu_kill;
    logic                r_redirect;
    logic [31:0]         r_redirect_pc;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         r_sum;
    logic [31:0]         r_expected;
    logic [31:0]         w_sum_next;
`endif

    assign in_ready    = (r_state == ST_LOAD);
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_stall   = r_cpu_stall;
    assign cpu_kill    = r_cpu_kill;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

    // Next-state, handshake decode and start validation
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_accept         = 1'b0;
        w_finish         = 1'b0;
        w_err_next       = 1'b0;
        w_xfer           = (r_state == ST_LOAD) && in_valid;
        w_last           = w_xfer && (r_remaining == LP_REM_ONE);
        w_end            = {2'b00, base_addr} + {1'b0, length};
        w_start_ok       = (length != '0) && (w_end <= LP_DEPTH);
`ifdef LOADER_CHECKSUM_EN
        w_sum_next       = r_sum + (w_xfer ? in_data : '0);
`endif
        case (r_state)
            ST_IDLE: begin
                // The done cycle still belongs to the FLUSH exit, so a start
                // seen there is dropped and must be repeated a cycle later.
                if (start && !r_done) begin
                    if (w_start_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_LOAD;
                    end else begin
                        w_err_next   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_sum_next != r_expected) begin
                        w_state_next = ST_HALT;
                        w_err_next   = 1'b1;
                    end else begin
`else
                    begin
`endif
                        w_state_next     = ST_FLUSH;
                        w_flush_cnt_next = LP_FLUSH_LAST;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_finish     = 1'b1;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_HALT: begin
                if (start) begin
                    if (w_start_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_LOAD;
                    end else begin
                        w_err_next   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Registered redirect lands in the last FLUSH cycle.
        w_redirect_next = (w_state_next == ST_FLUSH) && (w_flush_cnt_next == '0);
    end

    // State register and drain counter
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // Load counters, latched request and checksum accumulator
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_base      <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_expected  <= '0;
`endif
        end else if (w_accept) begin
            r_base      <= base_addr;
            r_addr      <= base_addr;
            r_remaining <= length;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_expected  <= expected_sum;
`endif
        end else if (w_xfer) begin
            r_remaining <= r_remaining - LP_REM_ONE;
            // Holding on the final word keeps a load ending at DEPTH-1 from wrapping.
            if (!w_last) begin
                r_addr  <= r_addr + LP_ADDR_ONE;
            end
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= w_sum_next;
`endif
        end
    end

    // Registered outputs: write port, pipeline control and status pulses
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cpu_stall   <= 1'b0;
            r_cpu_kill    <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_mem_we <= w_xfer;
            if (w_xfer) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= in_data;
            end
            r_cpu_stall   <= (w_state_next != ST_IDLE);
            r_cpu_kill    <= (w_state_next != ST_IDLE);
            r_busy        <= (w_state_next != ST_IDLE);
            r_redirect    <= w_redirect_next;
            r_redirect_pc <= w_redirect_next ? {{(32-ADDR_W){1'b0}}, r_base} : '0;
            r_done        <= w_finish;
            r_err         <= w_err_next;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven start vectors, hand-written
// multi-cycle sequences and randomized loads checked against a memory-image model.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DP = 256;
    localparam int FC = 4;

    logic          clk;
    logic          clear;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          in_valid;
    logic [31:0]   in_data;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   expected_sum;
`endif
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_stall;
    logic          cpu_kill;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(
        .ADDR_W(AW),
        .DEPTH(DP),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .clear(clear),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .in_valid(in_valid),
        .in_data(in_data),
`ifdef LOADER_CHECKSUM_EN
        .expected_sum(expected_sum),
`endif
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall),
        .cpu_kill(cpu_kill),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Cycle index and observed-event log
    int unsigned cyc = 0;
    int unsigned n_wr = 0, n_done = 0, n_redirect = 0, n_err = 0, viol = 0;
    int unsigned last_wr_cyc = 0, done_cyc = 0, redirect_cyc = 0;
    logic [31:0] rpc_seen = '0;
    logic        stall_at_done = 1'b0;
    logic [31:0] dut_mem[DP] = '{default: '0};
    logic [31:0] ref_mem[DP] = '{default: '0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            dut_mem[mem_addr] <= mem_wdata;
            n_wr              <= n_wr + 1;
            last_wr_cyc       <= cyc;
            if (!(cpu_stall && cpu_kill && busy)) viol <= viol + 1;
        end
        if (redirect) begin
            n_redirect   <= n_redirect + 1;
            redirect_cyc <= cyc;
            rpc_seen     <= redirect_pc;
        end
        if (done) begin
            n_done        <= n_done + 1;
            done_cyc      <= cyc;
            stall_at_done <= cpu_stall;
        end
        if (err) n_err <= n_err + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: in_valid held, 1: random gaps, 2: repeating 1,0,0,1 pattern
    task automatic feed(input logic [31:0] words[$], input int mode, output bit ok);
        int unsigned idx = 0;
        int unsigned k = 0;
        bit v, rdy;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        ok = 1'b1;
        while (idx < words.size()) begin
            if (k > 3000) begin
                ok = 1'b0;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = pat[k % 4];
            endcase
            in_valid = v;
            in_data  = v ? words[idx] : $urandom;
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (v && rdy) idx++;
            k++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, input logic [31:0] sum);
        base_addr = b;
        length    = l;
`ifdef LOADER_CHECKSUM_EN
        expected_sum = sum;
`else
        if (sum == 32'hDEAD_BEEF) in_data = sum;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] sum_of(input logic [31:0] words[$]);
        logic [31:0] s = '0;
        foreach (words[i]) s += words[i];
        return s;
    endfunction

    function automatic int unsigned image_mismatches();
        int unsigned m = 0;
        for (int i = 0; i < DP; i++) if (ref_mem[i] !== dut_mem[i]) m++;
        return m;
    endfunction

    task automatic load_case(input string nm, input logic [AW-1:0] b, input logic [AW:0] l,
                             input logic [31:0] words[$], input int mode, input bit exp_err);
        int unsigned w0 = n_wr;
        int unsigned d0 = n_done;
        int unsigned r0 = n_redirect;
        int unsigned s;
        bit ok;
        do_start(b, l, sum_of(words));
        s = cyc;
        check({nm, "_err"}, err, exp_err);
        check({nm, "_busy"}, busy, !exp_err);
        if (exp_err) begin
            tick();
            check({nm, "_errpulse"}, err, 0);
            tick();
            check({nm, "_nowr"}, n_wr - w0, 0);
            check({nm, "_idle"}, busy, 0);
            return;
        end
        check({nm, "_rdy"}, in_ready, 1);
        feed(words, mode, ok);
        check({nm, "_feed"}, ok, 1);
        wait_done(ok);
        check({nm, "_donewait"}, ok, 1);
        @(negedge clk);
        #1;
        foreach (words[i]) ref_mem[int'(b) + i] = words[i];
        check({nm, "_nwr"}, n_wr - w0, l);
        check({nm, "_image"}, image_mismatches(), 0);
        check({nm, "_ndone"}, n_done - d0, 1);
        check({nm, "_nredir"}, n_redirect - r0, 1);
        check({nm, "_rpc"}, rpc_seen, {24'b0, b});
        check({nm, "_rdly"}, done_cyc - redirect_cyc, 1);
        check({nm, "_flush"}, done_cyc - last_wr_cyc, FC);
        check({nm, "_stallrel"}, stall_at_done, 0);
        check({nm, "_viol"}, viol, 0);
        if (mode == 0) check({nm, "_lat"}, done_cyc - s, l + FC);
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] b;
        logic [AW:0]   l;
        bit            exp_err;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        logic [31:0] words[$];
        logic [31:0] part[$];
        int unsigned d0, r0, e0;
        bit ok;

        tbl[0] = '{b: 8'd0,   l: 9'd0,   exp_err: 1'b1};
        tbl[1] = '{b: 8'd250, l: 9'd7,   exp_err: 1'b1};
        tbl[2] = '{b: 8'd250, l: 9'd6,   exp_err: 1'b0};
        tbl[3] = '{b: 8'd255, l: 9'd1,   exp_err: 1'b0};
        tbl[4] = '{b: 8'd255, l: 9'd2,   exp_err: 1'b1};
        tbl[5] = '{b: 8'd128, l: 9'd129, exp_err: 1'b1};
        tbl[6] = '{b: 8'd0,   l: 9'd256, exp_err: 1'b0};
        tbl[7] = '{b: 8'd1,   l: 9'd256, exp_err: 1'b1};

        clear = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_data = '0;
`ifdef LOADER_CHECKSUM_EN
        expected_sum = '0;
`endif
        tick();
        tick();
        check("rst_ctrl", {in_ready, mem_we, cpu_stall, cpu_kill, redirect, busy, done, err}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rpc", redirect_pc, 0);
        clear = 1'b0;
        tick();
        tick();
        check("post_rst_ctrl", {in_ready, mem_we, cpu_stall, cpu_kill, redirect, busy, done, err}, 0);

        // Basic three-word load at address 0
        words = '{32'h15980003, 32'h15540003, 32'h14440005};
        load_case("basic", 8'd0, 9'd3, words, 0, 1'b0);

        // Backpressure with in_valid 1,0,0,1
        words = '{$urandom, $urandom};
        load_case("gaps", 8'd10, 9'd2, words, 2, 1'b0);

        // Start-validation table
        for (int t = 0; t < 8; t++) begin
            words.delete();
            if (!tbl[t].exp_err) for (int i = 0; i < int'(tbl[t].l); i++) words.push_back($urandom);
            load_case($sformatf("tbl%0d", t), tbl[t].b, tbl[t].l, words, 1, tbl[t].exp_err);
        end

        // Abort on clear after 2 of 5 words
        words = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        part  = '{words[0], words[1]};
        d0 = n_done;
        r0 = n_redirect;
        do_start(8'd20, 9'd5, sum_of(words));
        feed(part, 0, ok);
        check("abort_feed", ok, 1);
        @(negedge clk);
        #1;
        clear = 1'b1;
        #1;
        check("abort_ctrl", {in_ready, mem_we, cpu_stall, cpu_kill, redirect, busy, done, err}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        ref_mem[20] = words[0];
        ref_mem[21] = words[1];
        check("abort_image", image_mismatches(), 0);
        check("abort_nodone", n_done - d0, 0);
        check("abort_noredir", n_redirect - r0, 0);
        words = '{$urandom, $urandom, $urandom};
        load_case("after_abort", 8'd30, 9'd3, words, 0, 1'b0);

        // Start in the done cycle is dropped; one cycle later it is taken
        words = '{$urandom, $urandom};
        do_start(8'd40, 9'd2, sum_of(words));
        feed(words, 0, ok);
        wait_done(ok);
        check("dstart_done", ok, 1);
        part = '{$urandom};
        do_start(8'd50, 9'd1, sum_of(part));
        check("dstart_ignored", busy, 0);
        do_start(8'd50, 9'd1, sum_of(part));
        check("dstart_taken", busy, 1);
        feed(part, 0, ok);
        wait_done(ok);
        check("dstart_done2", ok, 1);
        tick();
        ref_mem[40] = words[0];
        ref_mem[41] = words[1];
        ref_mem[50] = part[0];
        check("dstart_image", image_mismatches(), 0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch parks in HALT until a new start
        words = '{32'd1, 32'd2};
        d0 = n_done;
        r0 = n_redirect;
        e0 = n_err;
        do_start(8'd0, 9'd2, 32'd4);
        feed(words, 0, ok);
        check("cks_err", err, 1);
        check("cks_stall", cpu_stall, 1);
        for (int i = 0; i < 10; i++) tick();
        check("cks_hold_stall", {cpu_stall, cpu_kill, busy}, 3'b111);
        check("cks_nodone", n_done - d0, 0);
        check("cks_noredir", n_redirect - r0, 0);
        check("cks_errcount", n_err - e0, 1);
        ref_mem[0] = 32'd1;
        ref_mem[1] = 32'd2;
        load_case("cks_ok", 8'd0, 9'd2, words, 0, 1'b0);
`else
        d0 = 0; r0 = 0; e0 = 0;
`endif

        // Randomized loads against the memory-image model
        for (int n = 0; n < 25; n++) begin
            int unsigned b, l;
            bit bad;
            b = $urandom_range(0, 255);
            l = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 300) : $urandom_range(1, 10);
            bad = (l == 0) || (b + l > DP);
            words.delete();
            if (!bad) for (int i = 0; i < int'(l); i++) words.push_back($urandom);
            load_case($sformatf("rnd%0d", n), AW'(b), (AW+1)'(l), words,
                      int'($urandom_range(0, 1)), bad);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
